// File: rtl/coin_credit_accumulator_pkg.sv
// Shared types and constants for the coffee vending credit front end.
package vending_pkg;
  localparam int CREDIT_W       = 4;
  localparam int COIN_100_UNITS = 1;
  localparam int COIN_500_UNITS = 5;

  typedef logic [CREDIT_W-1:0] credit_t;

  typedef enum logic {IDLE, DONE} buy_state_t;
endpackage

// File: rtl/coin_credit_accumulator_if.sv
// Coin, purchase and change signals between the vending controller and the accumulator.
interface coin_credit_accumulator_if;
  import vending_pkg::*;

  logic    coin_100;
  logic    coin_500;
  credit_t price;
  logic    buy_req;
  logic    cancel;
  credit_t total_coins;
  logic    credit_full;
  logic    coin_reject;
  logic    buy_ack;
  logic    buy_nack;
  credit_t change;
  logic    change_valid;

  modport master (
    output coin_100, coin_500, price, buy_req, cancel,
    input  total_coins, credit_full, coin_reject, buy_ack, buy_nack, change, change_valid
  );

  modport slave (
    input  coin_100, coin_500, price, buy_req, cancel,
    output total_coins, credit_full, coin_reject, buy_ack, buy_nack, change, change_valid
  );
endinterface

// File: rtl/coin_credit_accumulator_debouncer.sv
// Per-line coin front end: 2-flop synchroniser, stability counter, rising-edge pulse.
module coin_debouncer
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic coin_evt
);
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Sync the raw line, count consecutive disagreeing samples, flip the level after enough of them.
  // The event is registered on the same edge the level rises, so credit moves one edge later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level    <= 1'b0;
      cnt      <= '0;
      coin_evt <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      coin_evt <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level    <= sync2;
        cnt      <= '0;
        coin_evt <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: debounced coin intake, capped credit, purchase/cancel handshake.
// Credit width comes from vending_pkg::CREDIT_W.
module coin_credit_accumulator
  import vending_pkg::*;
#(
  parameter int MAX_CREDIT      = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  coin_credit_accumulator_if.slave   cif
);
  // Headroom so base + 5 + 1 can be compared against the ceiling without wrapping.
  localparam int SUM_W = CREDIT_W + 3;

  logic       evt_100;
  logic       evt_500;
  buy_state_t state;
  credit_t    total_q;
  credit_t    change_q;
  logic       full_q;
  logic       reject_q;
  logic       ack_q;
  logic       nack_q;
  logic       cv_q;

  logic             settle;
  logic             reject;
  logic [SUM_W-1:0] base;
  logic [SUM_W-1:0] after_500;
  logic [SUM_W-1:0] after_100;
  credit_t          next_credit;

  coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_100 (
    .clock   (clock),
    .reset   (reset),
    .raw     (cif.coin_100),
    .coin_evt(evt_100)
  );

  coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_500 (
    .clock   (clock),
    .reset   (reset),
    .raw     (cif.coin_500),
    .coin_evt(evt_500)
  );

  // Next credit: a charge or refund this cycle zeroes the base, then the 500 event, then the 100 event.
  always_comb begin
    settle    = 1'b0;
    reject    = 1'b0;
    if (state == IDLE) begin
      if (cif.buy_req) settle = (total_q >= cif.price);
      else             settle = cif.cancel && (total_q != '0);
    end
    base      = settle ? '0 : SUM_W'(total_q);
    after_500 = base;
    if (evt_500) begin
      if (base + SUM_W'(COIN_500_UNITS) <= SUM_W'(MAX_CREDIT)) after_500 = base + SUM_W'(COIN_500_UNITS);
      else                                                    reject    = 1'b1;
    end
    after_100 = after_500;
    if (evt_100) begin
      if (after_500 + SUM_W'(COIN_100_UNITS) <= SUM_W'(MAX_CREDIT)) after_100 = after_500 + SUM_W'(COIN_100_UNITS);
      else                                                         reject    = 1'b1;
    end
    next_credit = credit_t'(after_100);
  end

  // Credit register plus the buy/cancel FSM; every output is registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      total_q  <= '0;
      change_q <= '0;
      full_q   <= 1'b0;
      reject_q <= 1'b0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      cv_q     <= 1'b0;
    end else begin
      total_q  <= next_credit;
      full_q   <= (SUM_W'(next_credit) == SUM_W'(MAX_CREDIT));
      reject_q <= reject;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      cv_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (cif.buy_req) begin
            state <= DONE;
            if (total_q >= cif.price) begin
              change_q <= total_q - cif.price;
              ack_q    <= 1'b1;
              cv_q     <= 1'b1;
            end else begin
              nack_q   <= 1'b1;
            end
          end else if (cif.cancel && (total_q != '0)) begin
            state    <= DONE;
            change_q <= total_q;
            cv_q     <= 1'b1;
          end
        end
        DONE: begin
          if (!cif.buy_req && !cif.cancel) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cif.total_coins  = total_q;
  assign cif.credit_full  = full_q;
  assign cif.coin_reject  = reject_q;
  assign cif.buy_ack      = ack_q;
  assign cif.buy_nack     = nack_q;
  assign cif.change       = change_q;
  assign cif.change_valid = cv_q;
endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Scoreboard bench for coin_credit_accumulator: expected output events are queued as stimulus is
// driven, and a negedge monitor pops and compares them as the DUT produces them.
module tb_coin_credit_accumulator;
  localparam int K_REJ  = 0;
  localparam int K_TOT  = 1;
  localparam int K_ACK  = 2;
  localparam int K_NACK = 3;
  localparam int K_CV   = 4;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   prev_tot = 0;
  exp_t sb_q[$];
  string kname [5] = '{"rej", "tot", "ack", "nack", "cv"};

  coin_credit_accumulator_if dif();

  coin_credit_accumulator #(.MAX_CREDIT(10), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock),
    .reset(reset),
    .cif  (dif)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk($sformatf("sb_unexpected_%s", kname[kind]), val, 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", kind, e.kind);
      chk($sformatf("sb_%s", kname[e.kind]), val, e.val);
    end
  endtask

  // Output events in a fixed per-cycle order: reject, credit change, ack, nack, change.
  always @(negedge clock) begin
    if (mon_en) begin
      if (dif.coin_reject) observe(K_REJ, int'(dif.total_coins));
      if (int'(dif.total_coins) != prev_tot) observe(K_TOT, int'(dif.total_coins));
      prev_tot = int'(dif.total_coins);
      if (dif.buy_ack)      observe(K_ACK, int'(dif.change));
      if (dif.buy_nack)     observe(K_NACK, int'(dif.total_coins));
      if (dif.change_valid) observe(K_CV, int'(dif.change));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic c5, input logic c1);
    dif.coin_500 = c5;
    dif.coin_100 = c1;
    step(9);
    dif.coin_500 = 1'b0;
    dif.coin_100 = 1'b0;
    step(10);
  endtask

  task automatic do_cancel();
    dif.cancel = 1'b1;
    step(3);
    dif.cancel = 1'b0;
    step(2);
  endtask

  task automatic do_buy(input int p);
    dif.price   = 4'(p);
    dif.buy_req = 1'b1;
    step(3);
    dif.buy_req = 1'b0;
    step(2);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_total"}, dif.total_coins, 0);
    chk({pfx, "_full"},  dif.credit_full, 0);
    chk({pfx, "_rej"},   dif.coin_reject, 0);
    chk({pfx, "_ack"},   dif.buy_ack, 0);
    chk({pfx, "_nack"},  dif.buy_nack, 0);
    chk({pfx, "_chg"},   dif.change, 0);
    chk({pfx, "_cv"},    dif.change_valid, 0);
  endtask

  initial begin
    dif.coin_100 = 1'b0;
    dif.coin_500 = 1'b0;
    dif.price    = '0;
    dif.buy_req  = 1'b0;
    dif.cancel   = 1'b0;
    step(3);
    chk_all_zero("reset");
    reset  = 1'b1;
    mon_en = 1'b1;
    step(2);

    // coin_100 latency: first sampled at edge k, credit moves at k+6; falling edge is silent
    push(K_TOT, 1);
    dif.coin_100 = 1'b1;
    step(6);
    chk("lat_before", dif.total_coins, 0);
    step(1);
    chk("lat_after", dif.total_coins, 1);
    step(2);
    dif.coin_100 = 1'b0;
    step(12);
    chk("fall_no_event", dif.total_coins, 1);
    push(K_TOT, 0); push(K_CV, 1);
    do_cancel();

    // 2-cycle glitch on coin_500 is filtered, stable press gives one +5
    dif.coin_500 = 1'b1;
    step(2);
    dif.coin_500 = 1'b0;
    step(10);
    chk("glitch_filtered", dif.total_coins, 0);
    push(K_TOT, 5);
    press(1'b1, 1'b0);
    push(K_TOT, 6); press(1'b0, 1'b1);
    push(K_TOT, 7); press(1'b0, 1'b1);

    // credit 7: 500 does not fit
    push(K_REJ, 7);
    press(1'b1, 1'b0);
    chk("reject_hold", dif.total_coins, 7);

    // credit 7: 500 and 100 in the same cycle, 500 dropped, 100 kept
    push(K_REJ, 8); push(K_TOT, 8);
    press(1'b1, 1'b1);

    // credit 8, price 6, buy_req held 10 cycles: one charge only
    push(K_TOT, 0); push(K_ACK, 2); push(K_CV, 2);
    dif.price   = 4'd6;
    dif.buy_req = 1'b1;
    step(10);
    dif.buy_req = 1'b0;
    step(2);
    chk("buy_change", dif.change, 2);

    // credit 3 vs price 6: refused, credit unchanged, then refunded by cancel
    push(K_TOT, 1); press(1'b0, 1'b1);
    push(K_TOT, 2); press(1'b0, 1'b1);
    push(K_TOT, 3); press(1'b0, 1'b1);
    push(K_NACK, 3);
    do_buy(6);
    chk("nack_credit", dif.total_coins, 3);
    push(K_TOT, 0); push(K_CV, 3);
    do_cancel();

    // cancel with no credit: nothing happens, change holds
    do_cancel();
    chk("cancel_zero_chg", dif.change, 3);

    // price 0 with zero credit is accepted with zero change
    push(K_ACK, 0); push(K_CV, 0);
    do_buy(0);

    // coin event lands on the charge edge: change from pre-coin credit, new credit = coin
    push(K_TOT, 5);
    press(1'b1, 1'b0);
    push(K_TOT, 1); push(K_ACK, 3); push(K_CV, 3);
    dif.coin_100 = 1'b1;
    step(6);
    dif.price   = 4'd2;
    dif.buy_req = 1'b1;
    step(3);
    dif.buy_req = 1'b0;
    step(2);
    dif.coin_100 = 1'b0;
    step(10);
    chk("coincident_total", dif.total_coins, 1);
    push(K_TOT, 0); push(K_CV, 1);
    do_cancel();

    // fill to the ceiling, then overflow by 100
    push(K_TOT, 5);  press(1'b1, 1'b0);
    push(K_TOT, 10); press(1'b1, 1'b0);
    chk("full_set", dif.credit_full, 1);
    push(K_REJ, 10);
    press(1'b0, 1'b1);
    chk("full_hold", dif.total_coins, 10);
    push(K_TOT, 0); push(K_CV, 10);
    do_cancel();
    chk("full_clear", dif.credit_full, 0);

    // reset mid-transaction: credit lost, no ack
    push(K_TOT, 5);
    press(1'b1, 1'b0);
    push(K_TOT, 0);
    dif.price   = 4'd2;
    dif.buy_req = 1'b1;
    reset       = 1'b0;
    step(1);
    chk_all_zero("midreset");
    reset       = 1'b1;
    dif.buy_req = 1'b0;
    step(3);

    // coin line high through reset release gives exactly one event
    reset        = 1'b0;
    dif.coin_100 = 1'b1;
    step(2);
    push(K_TOT, 1);
    reset = 1'b1;
    step(14);
    chk("held_reset_evt", dif.total_coins, 1);
    dif.coin_100 = 1'b0;
    step(12);
    chk("held_reset_once", dif.total_coins, 1);

    step(5);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
